// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
//   Groups the panel-storage write bus and the win-checker handshake of the
//   Connect-4 game sequencer.
//
//   Parameters : ROWS, COLS (board size; they set the row/column widths)
//   Signals    : wr_en, wr_row, wr_col, wr_player  - single-cycle panel write
//                clear_panel                       - one-cycle panel clear
//                check_req, check_done, check_win  - win-checker handshake
//   Modports   : master (sequencer side), slave (panel/checker side)
// ---------------------------------------------------------------------------
interface game_sequencer_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS);

    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic          wr_player;
    logic          clear_panel;
    logic          check_req;
    logic          check_done;
    logic          check_win;

    modport master (
        output wr_en, wr_row, wr_col, wr_player, clear_panel, check_req,
        input  check_done, check_win
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_player, clear_panel, check_req,
        output check_done, check_win
    );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Turn and move sequencer for Connect-4. Owns the active column, the
//   per-column fill heights and the player to move. A put plays a row-by-row
//   drop animation, issues one panel write, then asks the win checker for a
//   verdict before passing the turn or ending the game.
//
//   Optional feature: define GAME_SEQ_TIMEOUT_EN to build an idle counter in
//   SELECT that forfeits the turn after TIMEOUT_CYCLES idle cycles. Without
//   the macro no counter exists and `timeout` is tied low.
//
//   Ports:
//     clk, rst                      clock, asynchronous active-low reset
//     left_pulse, right_pulse,
//     put_pulse, new_game           one-cycle control pulses
//     bus (game_sequencer_if.master) panel write + win-checker handshake
//     play                          one-hot active column
//     player                        player to move (0 = A, 1 = B)
//     anim_active, anim_row         drop animation status / drawn row
//     invalid_move, timeout         one-cycle registered event flags
//     win_a, win_b, full_panel      sticky game-over flags
//     state_dbg                     current FSM state encoding
//
//   Handshake: check_req rises in the first CHECK cycle and stays high until
//   a cycle in which check_done=1 is sampled at the clock edge; check_win is
//   only looked at in that cycle, and check_req is low in the next cycle.
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int ROWS           = 6,
    parameter int COLS           = 7,
    parameter int DROP_TICKS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int RW = $clog2(ROWS + 1),
    localparam int CW = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 left_pulse,
    input  logic                 right_pulse,
    input  logic                 put_pulse,
    input  logic                 new_game,
    game_sequencer_if.master     bus,
    output logic [COLS-1:0]      play,
    output logic                 player,
    output logic                 anim_active,
    output logic [RW-1:0]        anim_row,
    output logic                 invalid_move,
    output logic                 win_a,
    output logic                 win_b,
    output logic                 full_panel,
    output logic                 timeout,
    output logic [2:0]           state_dbg
);

    localparam int TKW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

    typedef enum logic [2:0] {
        S_SELECT = 3'd0,
        S_DROP   = 3'd1,
        S_COMMIT = 3'd2,
        S_CHECK  = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [RW-1:0]  height [COLS];
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  tgt_q;
    logic [TKW-1:0] tick;

    logic [CW-1:0]  cur_col;
    logic           cur_full;
    logic           all_full;
    logic           step;

    // ------------------------------------------------------------------
    // Column decode and board status
    // ------------------------------------------------------------------
    always_comb begin
        cur_col = '0;
        for (int i = 0; i < COLS; i++) begin
            if (play[i]) cur_col = CW'(i);
        end
    end

    assign cur_full = (height[cur_col] == RW'(ROWS));

    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (height[i] != RW'(ROWS)) all_full = 1'b0;
        end
    end

    // One animation step completes on the last tick of each row.
    assign step = (tick == TKW'(DROP_TICKS - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_SELECT;
        else      state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx      = state;
        bus.wr_en     = 1'b0;
        bus.wr_row    = '0;
        bus.wr_col    = '0;
        bus.wr_player = 1'b0;
        bus.check_req = 1'b0;
        case (state)
            S_SELECT: begin
                if (put_pulse && !cur_full) state_nx = S_DROP;
            end
            S_DROP: begin
                if (step && (anim_row == tgt_q)) state_nx = S_COMMIT;
            end
            S_COMMIT: begin
                bus.wr_en     = 1'b1;
                bus.wr_row    = tgt_q;
                bus.wr_col    = col_q;
                bus.wr_player = player;
                state_nx      = S_CHECK;
            end
            S_CHECK: begin
                bus.check_req = 1'b1;
                if (bus.check_done) begin
                    if (bus.check_win || all_full) state_nx = S_OVER;
                    else                           state_nx = S_SELECT;
                end
            end
            S_OVER: begin
                if (new_game) state_nx = S_SELECT;
            end
            default: state_nx = S_SELECT;
        endcase
    end

    assign state_dbg = state;

`ifdef GAME_SEQ_TIMEOUT_EN
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [IW-1:0] idle_cnt;
`else
    // The idle timeout is not built; keep the parameter referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Game datapath: column, heights, player, animation, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play            <= COLS'(1);
            player          <= 1'b0;
            for (int i = 0; i < COLS; i++) height[i] <= '0;
            col_q           <= '0;
            tgt_q           <= '0;
            tick            <= '0;
            anim_row        <= '0;
            anim_active     <= 1'b0;
            invalid_move    <= 1'b0;
            win_a           <= 1'b0;
            win_b           <= 1'b0;
            full_panel      <= 1'b0;
            bus.clear_panel <= 1'b0;
`ifdef GAME_SEQ_TIMEOUT_EN
            idle_cnt        <= '0;
            timeout         <= 1'b0;
`endif
        end else begin
            invalid_move    <= 1'b0;
            bus.clear_panel <= 1'b0;
`ifdef GAME_SEQ_TIMEOUT_EN
            timeout         <= 1'b0;
            // Cleared whenever we are outside SELECT, so entry starts at 0.
            idle_cnt        <= '0;
`endif
            case (state)
                S_SELECT: begin
                    // A put takes priority and uses the column before any move.
                    if (put_pulse) begin
                        if (cur_full) begin
                            invalid_move <= 1'b1;
                        end else begin
                            col_q       <= cur_col;
                            tgt_q       <= height[cur_col];
                            anim_row    <= RW'(ROWS - 1);
                            anim_active <= 1'b1;
                            tick        <= '0;
                        end
                    end else if (left_pulse && !right_pulse) begin
                        play <= {play[0], play[COLS-1:1]};
                    end else if (right_pulse && !left_pulse) begin
                        play <= {play[COLS-2:0], play[COLS-1]};
                    end
`ifdef GAME_SEQ_TIMEOUT_EN
                    if (left_pulse || right_pulse || put_pulse) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                        timeout  <= 1'b1;
                        player   <= ~player;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
`endif
                end
                S_DROP: begin
                    if (step) begin
                        tick <= '0;
                        if (anim_row != tgt_q) anim_row    <= anim_row - RW'(1);
                        else                   anim_active <= 1'b0;
                    end else begin
                        tick <= tick + TKW'(1);
                    end
                end
                S_COMMIT: begin
                    if (height[col_q] != RW'(ROWS)) height[col_q] <= height[col_q] + RW'(1);
                end
                S_CHECK: begin
                    if (bus.check_done) begin
                        if (bus.check_win) begin
                            if (player) win_b <= 1'b1;
                            else        win_a <= 1'b1;
                        end else if (all_full) begin
                            full_panel <= 1'b1;
                        end else begin
                            player <= ~player;
                        end
                    end
                end
                S_OVER: begin
                    if (new_game) begin
                        bus.clear_panel <= 1'b1;
                        for (int i = 0; i < COLS; i++) height[i] <= '0;
                        win_a      <= 1'b0;
                        win_b      <= 1'b0;
                        full_panel <= 1'b0;
                        player     <= 1'b0;
                        play       <= COLS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
